// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: default geometry, the read
// bypass priority (load writeback over ALU writeback) and slice indexing.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NRD    = 2;

    // Where a read port takes its data from this cycle.
    typedef enum logic [1:0] {
        SRC_STORED = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_LOAD   = 2'd2,
        SRC_ZERO   = 2'd3
    } rd_src_e;

    // Zero register beats the load bypass, which beats the ALU bypass.
    function automatic rd_src_e bypass_sel(input logic hit_load,
                                           input logic hit_alu,
                                           input logic is_zero);
        rd_src_e src;
        src = SRC_STORED;
        if (hit_alu)  src = SRC_ALU;
        if (hit_load) src = SRC_LOAD;
        if (is_zero)  src = SRC_ZERO;
        return src;
    endfunction

    // Low bit of element idx in a flattened vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-load bit per register plus per-port
// operand-valid flags. A load writeback makes its operand valid in the
// same cycle, matching the data bypass in the register array.
module regfile_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  set_busy,
    input  logic [ADDR_W-1:0]     busy_addr,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [NRD-1:0]        rv
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy: a new load issue (set) beats a load completion (clear).
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_busy_nxt[i] = r_busy[i];
            if (we1 && wa1 == ADDR_W'(i))
                w_busy_nxt[i] = 1'b0;
            if (set_busy && busy_addr == ADDR_W'(i))
                w_busy_nxt[i] = 1'b1;
            if (ZERO_REG != 0 && i == 0)
                w_busy_nxt[i] = 1'b0;
        end
    end

    // Scoreboard register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Operand valid per read port, with same-cycle load writeback bypass.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rv[k] = !r_busy[ra[k*ADDR_W +: ADDR_W]]
                    || (we1 && wa1 == ra[k*ADDR_W +: ADDR_W]);
            if (ZERO_REG != 0 && ra[k*ADDR_W +: ADDR_W] == '0)
                rv[k] = 1'b1;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read, dual-write register file with write-first bypass, optional
// hardwired zero register and a busy scoreboard for pending loads.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NRD*ADDR_W-1:0]        ra,
    output logic [NRD*DATA_W-1:0]        rd,
    output logic [NRD-1:0]               rv,
    input  logic                         we0,
    input  logic [ADDR_W-1:0]            wa0,
    input  logic [DATA_W-1:0]            wd0,
    input  logic                         we1,
    input  logic [ADDR_W-1:0]            wa1,
    input  logic [DATA_W-1:0]            wd1,
    input  logic                         set_busy,
    input  logic [ADDR_W-1:0]            busy_addr,
    output logic [2**ADDR_W-1:0]         busy,
    output logic [(2**ADDR_W)*DATA_W-1:0] r_all
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [NREGS];
    rd_src_e           w_src [NRD];

    // Register array; the load port wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NREGS; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (we1 && wa1 == ADDR_W'(i))
                        r_mem[i] <= wd1;
                    else if (we0 && wa0 == ADDR_W'(i))
                        r_mem[i] <= wd0;
                end
            end
        end
    end

    // Pick the data source for each read port.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_src[k] = bypass_sel(we1 && wa1 == ra[k*ADDR_W +: ADDR_W],
                                  we0 && wa0 == ra[k*ADDR_W +: ADDR_W],
                                  ZERO_REG != 0 && ra[k*ADDR_W +: ADDR_W] == '0);
        end
    end

    // Read data mux driven by the selected source.
    always_comb begin
        rd = '0;
        for (int k = 0; k < NRD; k++) begin
            case (w_src[k])
                SRC_LOAD: rd[slice_lo(k, DATA_W) +: DATA_W] = wd1;
                SRC_ALU:  rd[slice_lo(k, DATA_W) +: DATA_W] = wd0;
                SRC_ZERO: rd[slice_lo(k, DATA_W) +: DATA_W] = '0;
                default:  rd[slice_lo(k, DATA_W) +: DATA_W] = r_mem[ra[k*ADDR_W +: ADDR_W]];
            endcase
        end
    end

    // Debug view of stored contents, no bypass.
    always_comb begin
        r_all = '0;
        for (int i = 0; i < NREGS; i++)
            r_all[slice_lo(i, DATA_W) +: DATA_W] = r_mem[i];
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .n_rst     (n_rst),
        .set_busy  (set_busy),
        .busy_addr (busy_addr),
        .we1       (we1),
        .wa1       (wa1),
        .ra        (ra),
        .busy      (busy),
        .rv        (rv)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (default geometry, and a
// 16-bit / 16-register / 3-port variant with the zero register) share one
// stimulus stream and are checked against an array-based reference model.
module tb_register_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, sized for the larger instance.
  logic        s_n_rst;
  logic        s_we0, s_we1, s_sb;
  logic [3:0]  s_wa0, s_wa1, s_ba;
  logic [31:0] s_wd0, s_wd1;
  logic [3:0]  s_ra [3];

  // Instance A: DATA_W=32, ADDR_W=3, NRD=2, ZERO_REG=0
  logic [5:0]   ra_a;
  logic [63:0]  rd_a;
  logic [1:0]   rv_a;
  logic [7:0]   busy_a;
  logic [255:0] r_all_a;

  // Instance B: DATA_W=16, ADDR_W=4, NRD=3, ZERO_REG=1
  logic [11:0]  ra_b;
  logic [47:0]  rd_b;
  logic [2:0]   rv_b;
  logic [15:0]  busy_b;
  logic [255:0] r_all_b;

  assign ra_a = {s_ra[1][2:0], s_ra[0][2:0]};
  assign ra_b = {s_ra[2], s_ra[1], s_ra[0]};

  register_file_sb u_a (
    .clk(clk), .n_rst(s_n_rst), .ra(ra_a), .rd(rd_a), .rv(rv_a),
    .we0(s_we0), .wa0(s_wa0[2:0]), .wd0(s_wd0),
    .we1(s_we1), .wa1(s_wa1[2:0]), .wd1(s_wd1),
    .set_busy(s_sb), .busy_addr(s_ba[2:0]), .busy(busy_a), .r_all(r_all_a)
  );

  register_file_sb #(.DATA_W(16), .ADDR_W(4), .NRD(3), .ZERO_REG(1)) u_b (
    .clk(clk), .n_rst(s_n_rst), .ra(ra_b), .rd(rd_b), .rv(rv_b),
    .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0[15:0]),
    .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1[15:0]),
    .set_busy(s_sb), .busy_addr(s_ba), .busy(busy_b), .r_all(r_all_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [2][16];
  logic        m_busy [2][16];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int amask(input int d, input logic [3:0] a);
    return (d == 0) ? int'(a[2:0]) : int'(a);
  endfunction

  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'hffff_ffff : 32'h0000_ffff;
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input logic [3:0] a);
    int ai;
    ai = amask(d, a);
    if (d == 1 && ai == 0) return 32'h0;
    if (s_we1 && amask(d, s_wa1) == ai) return s_wd1 & dmask(d);
    if (s_we0 && amask(d, s_wa0) == ai) return s_wd0 & dmask(d);
    return m_mem[d][ai];
  endfunction

  function automatic logic exp_rv(input int d, input logic [3:0] a);
    int ai;
    ai = amask(d, a);
    if (d == 1 && ai == 0) return 1'b1;
    return !m_busy[d][ai] || (s_we1 && amask(d, s_wa1) == ai);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!s_n_rst) begin
        for (int i = 0; i < 16; i++) begin
          m_mem[d][i]  = '0;
          m_busy[d][i] = 1'b0;
        end
      end else begin
        if (s_we0 && !(d == 1 && amask(d, s_wa0) == 0))
          m_mem[d][amask(d, s_wa0)] = s_wd0 & dmask(d);
        if (s_we1 && !(d == 1 && amask(d, s_wa1) == 0))
          m_mem[d][amask(d, s_wa1)] = s_wd1 & dmask(d);
        if (s_we1) m_busy[d][amask(d, s_wa1)] = 1'b0;
        if (s_sb)  m_busy[d][amask(d, s_ba)]  = 1'b1;
        if (d == 1) m_busy[d][0] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic [255:0] ea, eb;
    logic [15:0]  bb;
    for (int k = 0; k < 2; k++) begin
      check_val("rd_a", 256'(rd_a[k*32 +: 32]), 256'(exp_rd(0, s_ra[k])));
      check_val("rv_a", 256'(rv_a[k]), 256'(exp_rv(0, s_ra[k])));
    end
    for (int k = 0; k < 3; k++) begin
      check_val("rd_b", 256'(rd_b[k*16 +: 16]), 256'(exp_rd(1, s_ra[k])));
      check_val("rv_b", 256'(rv_b[k]), 256'(exp_rv(1, s_ra[k])));
    end
    ea = '0; eb = '0; bb = '0;
    for (int i = 0; i < 8; i++) begin
      ea[i*32 +: 32] = m_mem[0][i];
      bb[i] = m_busy[0][i];
    end
    check_val("busy_a", 256'(busy_a), 256'(bb[7:0]));
    check_val("r_all_a", r_all_a, ea);
    bb = '0;
    for (int i = 0; i < 16; i++) begin
      eb[i*16 +: 16] = m_mem[1][i][15:0];
      bb[i] = m_busy[1][i];
    end
    check_val("busy_b", 256'(busy_b), 256'(bb));
    check_val("r_all_b", r_all_b, eb);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    s_n_rst = 1'b1;
    s_we0 = 1'b0; s_we1 = 1'b0; s_sb = 1'b0;
    s_wa0 = '0; s_wa1 = '0; s_ba = '0;
    s_wd0 = '0; s_wd1 = '0;
    for (int k = 0; k < 3; k++) s_ra[k] = 4'(k);
  endtask

  // Inputs are applied just after a falling edge; combinational outputs are
  // sampled 2 time units later, then the model advances on the rising edge.
  task automatic run_cycle(input bit do_check);
    #2;
    if (do_check) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        m_mem[d][i] = '0;
        m_busy[d][i] = 1'b0;
      end

    // 1. reset, then read ports {2,1}
    idle(); s_n_rst = 1'b0;
    run_cycle(1'b0);
    idle(); s_ra[0] = 4'd1; s_ra[1] = 4'd2;
    run_cycle(1'b1);

    // 2. ALU write with same-cycle bypass
    idle(); s_we0 = 1'b1; s_wa0 = 4'd3; s_wd0 = 32'haaaa_aaaa; s_ra[0] = 4'd3;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd3;
    run_cycle(1'b1);

    // 3. write conflict, load wins
    idle(); s_we0 = 1'b1; s_wa0 = 4'd5; s_wd0 = 32'h1234_5678;
    s_we1 = 1'b1; s_wa1 = 4'd5; s_wd1 = 32'h8765_4321; s_ra[0] = 4'd5;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd5;
    run_cycle(1'b1);

    // 4. scoreboard set, bypassed clear, set beats clear
    idle(); s_sb = 1'b1; s_ba = 4'd6;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd6;
    run_cycle(1'b1);
    idle(); s_we1 = 1'b1; s_wa1 = 4'd6; s_wd1 = 32'h1111_1111; s_ra[0] = 4'd6;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd6;
    run_cycle(1'b1);
    idle(); s_sb = 1'b1; s_ba = 4'd6; s_we1 = 1'b1; s_wa1 = 4'd6; s_wd1 = 32'h2222_2222;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd6;
    run_cycle(1'b1);

    // 5. writes and busy marking on register 0
    idle(); s_we0 = 1'b1; s_wa0 = 4'd0; s_wd0 = 32'hffff_ffff;
    s_sb = 1'b1; s_ba = 4'd0; s_ra[0] = 4'd0;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd0; s_ra[1] = 4'd0;
    run_cycle(1'b1);

    // 6. reset mid-operation overrides write and set_busy
    for (int i = 1; i < 8; i++) begin
      idle(); s_we0 = 1'b1; s_wa0 = 4'(i); s_wd0 = $urandom;
      run_cycle(1'b1);
    end
    idle(); s_sb = 1'b1; s_ba = 4'd2;
    run_cycle(1'b1);
    idle(); s_n_rst = 1'b0; s_we0 = 1'b1; s_wa0 = 4'd4; s_wd0 = 32'hdead_beef;
    s_sb = 1'b1; s_ba = 4'd5;
    run_cycle(1'b1);
    idle(); s_ra[0] = 4'd4; s_ra[1] = 4'd5; s_ra[2] = 4'd2;
    run_cycle(1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      s_n_rst = ($urandom_range(0, 39) != 0);
      s_we0 = 1'($urandom_range(0, 1));
      s_we1 = 1'($urandom_range(0, 1));
      s_sb  = ($urandom_range(0, 2) == 0);
      s_wa0 = 4'($urandom_range(0, 15));
      s_wa1 = 4'($urandom_range(0, 15));
      s_ba  = 4'($urandom_range(0, 15));
      s_wd0 = $urandom;
      s_wd1 = $urandom;
      for (int k = 0; k < 3; k++) s_ra[k] = 4'($urandom_range(0, 15));
      run_cycle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
